// File: rtl/gift_pkg.sv
// Shared GIFT-128 constants, FSM state type and key/constant update functions
// used by the key-schedule round generator and the encryption round stage.
package gift_pkg;

  localparam int GIFT_KEY_W     = 128;
  localparam int GIFT_RC_W      = 6;
  localparam int GIFT128_ROUNDS = 40;
  localparam logic [GIFT_RC_W-1:0] GIFT_RC_INIT = 6'h01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } gift_state_e;

  // K' = rotr2(k1) || rotr12(k0) || K[127:32], rotations on 16-bit words.
  function automatic logic [GIFT_KEY_W-1:0] gift_key_update(input logic [GIFT_KEY_W-1:0] k);
    logic [15:0] k0;
    logic [15:0] k1;
    k0 = k[15:0];
    k1 = k[31:16];
    return {k1[1:0], k1[15:2], k0[11:0], k0[15:12], k[127:32]};
  endfunction

  function automatic logic [GIFT_RC_W-1:0] gift_rc_next(input logic [GIFT_RC_W-1:0] c);
    return {c[4:0], c[5] ^ c[4] ^ 1'b1};
  endfunction

endpackage

// File: rtl/gift_rc_lfsr.sv
// 6-bit GIFT round-constant register: load on start, step per accepted round,
// otherwise hold.
module gift_rc_lfsr
  import gift_pkg::*;
(
  input  logic                 inClk,
  input  logic                 inRstN,
  input  logic                 inLoad,
  input  logic                 inStep,
  input  logic [GIFT_RC_W-1:0] inLoadVal,
  output logic [GIFT_RC_W-1:0] outRc
);

  logic [GIFT_RC_W-1:0] rcReg;

  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      rcReg <= '0;
    end else if (inLoad) begin
      rcReg <= inLoadVal;
    end else if (inStep) begin
      rcReg <= gift_rc_next(rcReg);
    end
  end

  assign outRc = rcReg;

endmodule

// File: rtl/gift_keysch_round_gen.sv
// Sequential GIFT-128 round-key generator: captures the master key on start and
// streams ROUNDS (U, V, constant) triples to the round datapath.
module gift_keysch_round_gen
  import gift_pkg::*;
#(
  parameter int ROUNDS = GIFT128_ROUNDS
) (
  input  logic                  inClk,
  input  logic                  inRstN,
  input  logic                  inStart,
  input  logic [GIFT_KEY_W-1:0] inKey,
  input  logic [GIFT_RC_W-1:0]  inRoundConst,
  output logic                  outBusy,
  output logic                  outRkValid,
  input  logic                  inRkReady,
  output logic [31:0]           outRkU,
  output logic [31:0]           outRkV,
  output logic [GIFT_RC_W-1:0]  outRkConst,
  output logic [5:0]            outRkIndex,
  output logic                  outDone,
  output logic [1:0]            outDbgState
);

  localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

  gift_state_e           state;
  gift_state_e           nextState;
  logic [GIFT_KEY_W-1:0] keyReg;
  logic [5:0]            idxReg;
  logic                  rkValid;
  logic                  startAcc;
  logic                  transfer;
  logic                  step;

  // Valid/ready: a round key transfers on any edge where outRkValid && inRkReady;
  // once valid is raised it stays high and all outRk* hold until that transfer.
  assign startAcc = (state == IDLE) && inStart;
  assign transfer = rkValid && inRkReady;
  assign step     = transfer && (idxReg != LAST_IDX);

  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (inStart) nextState = RUN;
      RUN:     if (transfer && (idxReg == LAST_IDX)) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    rkValid = 1'b0;
    outDone = 1'b0;
    outBusy = 1'b0;
    case (state)
      RUN:  begin rkValid = 1'b1; outBusy = 1'b1; end
      DONE: begin outDone = 1'b1; outBusy = 1'b1; end
      default: ;
    endcase
  end

  // Key state and index hold on the final transfer so DONE still shows the last key.
  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      keyReg <= '0;
      idxReg <= '0;
    end else if (startAcc) begin
      keyReg <= inKey;
      idxReg <= '0;
    end else if (step) begin
      keyReg <= gift_key_update(keyReg);
      idxReg <= idxReg + 6'd1;
    end
  end

  gift_rc_lfsr u_rc_lfsr (
    .inClk     (inClk),
    .inRstN    (inRstN),
    .inLoad    (startAcc),
    .inStep    (step),
    .inLoadVal (inRoundConst),
    .outRc     (outRkConst)
  );

  assign outRkValid  = rkValid;
  assign outRkU      = keyReg[95:64];
  assign outRkV      = keyReg[31:0];
  assign outRkIndex  = idxReg;
  assign outDbgState = state;

endmodule

// File: tb/tb_gift_keysch_round_gen.sv
// Randomized bench for gift_keysch_round_gen against a word-array reference of
// the GIFT-128 key schedule, with a negedge monitor draining an expected queue.
module tb_gift_keysch_round_gen;

  localparam int ROUNDS = 40;
  localparam int W      = 76;
  localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;

  logic         inClk = 1'b0;
  logic         inRstN = 1'b0;
  logic         inStart = 1'b0;
  logic [127:0] inKey = '0;
  logic [5:0]   inRoundConst = '0;
  logic         inRkReady = 1'b0;
  logic         outBusy;
  logic         outRkValid;
  logic [31:0]  outRkU;
  logic [31:0]  outRkV;
  logic [5:0]   outRkConst;
  logic [5:0]   outRkIndex;
  logic         outDone;
  logic [1:0]   outDbgState;

  logic [W-1:0] exp_q[$];
  logic [5:0]   model_last_const;
  int compared = 0;
  int mismatched = 0;
  int done_cnt = 0;

  gift_keysch_round_gen #(.ROUNDS(ROUNDS)) dut (
    .inClk        (inClk),
    .inRstN       (inRstN),
    .inStart      (inStart),
    .inKey        (inKey),
    .inRoundConst (inRoundConst),
    .outBusy      (outBusy),
    .outRkValid   (outRkValid),
    .inRkReady    (inRkReady),
    .outRkU       (outRkU),
    .outRkV       (outRkV),
    .outRkConst   (outRkConst),
    .outRkIndex   (outRkIndex),
    .outDone      (outDone),
    .outDbgState  (outDbgState)
  );

  // clock / reset
  always #5 inClk = ~inClk;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: key as eight 16-bit words; each round drops k0,k1 and appends
  // rotated copies of them at the top.
  task automatic build_exp(input logic [127:0] key, input logic [5:0] rc);
    logic [15:0] w[8];
    logic [15:0] t0;
    logic [15:0] t1;
    logic [5:0]  c;
    for (int i = 0; i < 8; i++) w[i] = key[16*i +: 16];
    c = rc;
    exp_q.delete();
    for (int r = 0; r < ROUNDS; r++) begin
      exp_q.push_back({w[5], w[4], w[1], w[0], c, 6'(r)});
      model_last_const = c;
      t0 = w[0];
      t1 = w[1];
      for (int i = 0; i < 6; i++) w[i] = w[i+2];
      w[6] = (t0 >> 12) | (t0 << 4);
      w[7] = (t1 >> 2) | (t1 << 14);
      c = ((c << 1) & 6'h3e) | 6'(((c >> 5) ^ (c >> 4) ^ 6'd1) & 6'd1);
    end
  endtask

  // scoreboard monitor
  always @(negedge inClk) begin
    if (inRstN) begin
      if (outDone) done_cnt++;
      check_val("busy", outBusy, outRkValid | outDone);
      if (outRkValid) begin
        check_val("key_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          check_val("rk", {outRkU, outRkV, outRkConst, outRkIndex}, exp_q[0]);
          if (inRkReady) void'(exp_q.pop_front());
        end
      end
    end
  end

  // mode: 0 ready high, 1 random ready, 2 stall 5 cycles at index 3
  task automatic run_key(input logic [127:0] key, input logic [5:0] rc, input int mode,
                         input bit inject, input int abort_at);
    int cycles = 0;
    int stall = 0;
    int valid_cycles = 0;
    int done_before;
    bit finished = 0;
    build_exp(key, rc);
    done_before = done_cnt;
    @(posedge inClk); #1;
    inStart = 1'b1;
    inKey = key;
    inRoundConst = rc;
    inRkReady = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge inClk); #1;
    inStart = 1'b0;
    check_val("start_latency", outRkValid, 1);
    if (key == KEY_A && rc == 6'h01) begin
      check_val("idx0_u", outRkU, 32'h04050607);
      check_val("idx0_v", outRkV, 32'h0c0d0e0f);
      check_val("idx0_const", outRkConst, 6'h01);
    end
    while (!finished && cycles < 400) begin
      inKey = {$urandom, $urandom, $urandom, $urandom};
      inRoundConst = 6'($urandom_range(0, 63));
      if (outDone) begin
        finished = 1;
      end else begin
        if (outRkValid) valid_cycles++;
        if (abort_at >= 0 && outRkValid && outRkIndex == 6'(abort_at)) begin
          #2 inRstN = 1'b0;
          #1;
          check_val("rst_valid", outRkValid, 0);
          check_val("rst_busy", outBusy, 0);
          check_val("rst_done", outDone, 0);
          check_val("rst_rk", {outRkU, outRkV, outRkConst, outRkIndex}, 0);
          exp_q.delete();
          inStart = 1'b0;
          repeat (3) @(posedge inClk);
          #1 inRstN = 1'b1;
          @(posedge inClk); #1;
          check_val("rst_no_done", done_cnt - done_before, 0);
          check_val("rst_idle", outBusy, 0);
          return;
        end
        inStart = inject && outRkValid && (outRkIndex == 6'd10);
        case (mode)
          1: inRkReady = 1'($urandom_range(0, 1));
          2: begin
            inRkReady = !(outRkValid && outRkIndex == 6'd3 && stall < 5);
            if (!inRkReady) stall++;
          end
          default: inRkReady = 1'b1;
        endcase
        @(posedge inClk); #1;
        cycles++;
      end
    end
    check_val("done_seen", finished, 1);
    if (mode == 0) check_val("valid_cycles", valid_cycles, ROUNDS);
    check_val("queue_drained", exp_q.size(), 0);
    check_val("last_index", outRkIndex, ROUNDS - 1);
    check_val("last_const", outRkConst, model_last_const);
    if (rc == 6'h01) check_val("last_const_1a", outRkConst, 6'h1a);
    inStart = inject;
    @(posedge inClk); #1;
    inStart = 1'b0;
    check_val("idle_after_done", outBusy, 0);
    check_val("done_once", done_cnt - done_before, 1);
  endtask

  initial begin
    inRstN = 1'b0;
    #1;
    check_val("reset_valid", outRkValid, 0);
    check_val("reset_busy", outBusy, 0);
    check_val("reset_done", outDone, 0);
    check_val("reset_rk", {outRkU, outRkV, outRkConst, outRkIndex}, 0);
    repeat (2) @(posedge inClk);
    #1 inRstN = 1'b1;
    repeat (3) @(posedge inClk);
    #1 check_val("idle_no_start", outBusy, 0);

    run_key(KEY_A, 6'h01, 0, 0, -1);
    run_key(KEY_A, 6'h01, 2, 0, -1);
    run_key(KEY_A, 6'h01, 1, 0, -1);
    run_key(128'h0, 6'h01, 0, 0, -1);
    run_key({$urandom, $urandom, $urandom, $urandom}, 6'h01, 0, 1, -1);
    run_key(KEY_A, 6'h01, 0, 0, 20);
    run_key(KEY_A, 6'h01, 0, 0, -1);
    for (int n = 0; n < 4; n++) begin
      run_key({$urandom, $urandom, $urandom, $urandom}, 6'($urandom_range(0, 63)), 1, 1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
